// File: rtl/imm_arbiter.sv
// Two-requester round-robin arbiter feeding one shared RV32I immediate generator.
// The decoded immediate, format code and owner id are held in a one-entry response slot.
module imm_arbiter #(
    parameter int PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_inst,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_inst,
    output logic        req1_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_imm,
    output logic        rsp_id,
    output logic [2:0]  rsp_fmt
);

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_JALR = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_UJ   = 3'd4;
    localparam logic [2:0] FMT_SB   = 3'd5;
    localparam logic [2:0] FMT_UNK  = 3'd6;

    localparam logic PRIO_RST = (PRIO_INIT != 0);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prio;
    logic signed [31:0] r_imm_p1;
    logic [2:0]         r_fmt_p1;
    logic               r_id_p1;

    logic               w_slot_free;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_gnt;
    logic [31:0]        w_inst;
    logic [2:0]         w_fmt;
    logic signed [31:0] w_imm;

    function automatic logic [2:0] fmt_decode(input logic [31:0] inst);
        logic [2:0] f;
        case ({inst[6:5], inst[3:2]})
            4'b0000:          f = FMT_I;
            4'b1101:          f = FMT_JALR;
            4'b0100:          f = FMT_S;
            4'b0101, 4'b0001: f = FMT_U;
            4'b1111:          f = FMT_UJ;
            4'b1100:          f = FMT_SB;
            default:          f = FMT_UNK;
        endcase
        return f;
    endfunction

    // Unrecognised keys fall through to the I-type layout.
    function automatic logic signed [31:0] imm_gen(input logic [31:0] inst, input logic [2:0] fmt);
        logic signed [31:0] imm;
        case (fmt)
            FMT_JALR: imm = {{21{inst[31]}}, inst[30:21], 1'b0};
            FMT_S:    imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
            FMT_U:    imm = {inst[31:12], 12'b0};
            FMT_UJ:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_SB:   imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            default:  imm = {{21{inst[31]}}, inst[30:20]};
        endcase
        return imm;
    endfunction

    // Slot accepts when empty or being drained this cycle; never during reset.
    assign w_slot_free = !reset && ((r_state == ST_EMPTY) || rsp_ready);
    assign w_gnt0      = w_slot_free && req0_valid && (!req1_valid || (r_prio == 1'b0));
    assign w_gnt1      = w_slot_free && req1_valid && (!req0_valid || (r_prio == 1'b1));
    assign w_gnt       = w_gnt0 || w_gnt1;

    assign w_inst = w_gnt1 ? req1_inst : req0_inst;
    assign w_fmt  = fmt_decode(w_inst);
    assign w_imm  = imm_gen(w_inst, w_fmt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_gnt) w_state_nxt = ST_FULL;
            ST_FULL:  if (rsp_ready && !w_gnt) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        req0_ready = w_gnt0;
        req1_ready = w_gnt1;
        rsp_valid  = (r_state == ST_FULL);
    end

    // Priority passes to the requester that was not just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= PRIO_RST;
        end else if (w_gnt) begin
            r_prio <= w_gnt0;
        end
    end

    // ---- stage p1: response slot ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_imm_p1 <= '0;
            r_fmt_p1 <= '0;
            r_id_p1  <= 1'b0;
        end else if (w_gnt) begin
            r_imm_p1 <= w_imm;
            r_fmt_p1 <= w_fmt;
            r_id_p1  <= w_gnt1;
        end
    end

    assign rsp_imm = r_imm_p1;
    assign rsp_fmt = r_fmt_p1;
    assign rsp_id  = r_id_p1;

endmodule

// File: tb/tb_imm_arbiter.sv
// Directed bench for imm_arbiter: reset, format decode, contention, backpressure, mid-run reset.
module tb_imm_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [31:0] req0_inst;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_inst;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_imm;
    logic        rsp_id;
    logic [2:0]  rsp_fmt;

    int n_checks = 0;
    int n_fail   = 0;

    imm_arbiter #(.PRIO_INIT(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_inst  (req0_inst),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_inst  (req1_inst),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_imm    (rsp_imm),
        .rsp_id     (rsp_id),
        .rsp_fmt    (rsp_fmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One lone request; checks the grant cycle, then the response one cycle later.
    task automatic single(input int idx, input logic [31:0] inst,
                          input logic [31:0] exp_imm, input logic [2:0] exp_fmt, input string tag);
        req0_valid = (idx == 0);
        req1_valid = (idx == 1);
        req0_inst  = inst;
        req1_inst  = inst;
        rsp_ready  = 1'b1;
        @(negedge clk);
        check({tag, ".empty"}, 32'(rsp_valid), 32'd0);
        check({tag, ".rdy0"},  32'(req0_ready), 32'(idx == 0));
        check({tag, ".rdy1"},  32'(req1_ready), 32'(idx == 1));
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check({tag, ".vld"}, 32'(rsp_valid), 32'd1);
        check({tag, ".imm"}, rsp_imm, exp_imm);
        check({tag, ".fmt"}, 32'(rsp_fmt), 32'(exp_fmt));
        check({tag, ".id"},  32'(rsp_id), 32'(idx));
        next_cycle();
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1;
        req0_inst  = 32'hFFF00093;
        req1_valid = 1'b0;
        req1_inst  = 32'h0;
        rsp_ready  = 1'b1;

        // Reset state with a requester already valid.
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("rst.rdy0", 32'(req0_ready), 32'd0);
        check("rst.vld",  32'(rsp_valid), 32'd0);
        check("rst.imm",  rsp_imm, 32'd0);
        check("rst.fmt",  32'(rsp_fmt), 32'd0);
        check("rst.id",   32'(rsp_id), 32'd0);
        next_cycle();
        reset = 1'b0;

        single(0, 32'hFFF00093, 32'hFFFFFFFF, 3'd0, "single_i");
        single(1, 32'h12345037, 32'h12345000, 3'd3, "fmt_u");
        single(0, 32'hFE112E23, 32'hFFFFFFFC, 3'd2, "fmt_s");
        single(1, 32'h0040006F, 32'h00000004, 3'd4, "fmt_uj");
        single(0, 32'h80000003, 32'hFFFFF800, 3'd0, "key0000");
        single(1, 32'h8000000B, 32'hFFFFF800, 3'd6, "fmt_unk");
        single(0, 32'h00D00067, 32'h0000000C, 3'd1, "fmt_jalr");
        single(1, 32'h00000463, 32'h00000008, 3'd5, "fmt_sb");

        // Contention from a known priority: grants alternate 0,1,0,1.
        reset = 1'b1;
        next_cycle();
        reset      = 1'b0;
        req0_valid = 1'b1;
        req0_inst  = 32'h00100093;
        req1_valid = 1'b1;
        req1_inst  = 32'h00200093;
        rsp_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cont.rdy0", 32'(req0_ready), 32'(k % 2 == 0));
            check("cont.rdy1", 32'(req1_ready), 32'(k % 2 == 1));
            if (k > 0) begin
                check("cont.vld", 32'(rsp_valid), 32'd1);
                check("cont.id",  32'(rsp_id), 32'((k - 1) % 2));
                check("cont.imm", rsp_imm, ((k - 1) % 2 == 0) ? 32'd1 : 32'd2);
            end
            next_cycle();
        end

        // Backpressure: slot full with requester 1's response.
        rsp_ready = 1'b0;
        req0_inst = 32'h12345037;
        req1_inst = 32'hFFFFFFFF;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check("bp.rdy0", 32'(req0_ready), 32'd0);
            check("bp.rdy1", 32'(req1_ready), 32'd0);
            check("bp.vld",  32'(rsp_valid), 32'd1);
            check("bp.id",   32'(rsp_id), 32'd1);
            check("bp.imm",  rsp_imm, 32'd2);
            check("bp.fmt",  32'(rsp_fmt), 32'd0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rel.rdy0", 32'(req0_ready), 32'd1);
        check("rel.rdy1", 32'(req1_ready), 32'd0);
        check("rel.id",   32'(rsp_id), 32'd1);
        next_cycle();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("rel.vld",  32'(rsp_valid), 32'd1);
        check("rel.nid",  32'(rsp_id), 32'd0);
        check("rel.nimm", rsp_imm, 32'h12345000);
        check("rel.nfmt", 32'(rsp_fmt), 32'd3);
        next_cycle();
        req0_inst = 32'hFE112E23;
        @(negedge clk);
        check("hold.imm", rsp_imm, 32'h12345000);
        check("hold.fmt", 32'(rsp_fmt), 32'd3);
        next_cycle();

        // Reset while full and stalled; priority had moved to requester 1.
        reset = 1'b1;
        @(negedge clk);
        check("mrst.rdy0", 32'(req0_ready), 32'd0);
        check("mrst.rdy1", 32'(req1_ready), 32'd0);
        next_cycle();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("mrst.vld",  32'(rsp_valid), 32'd0);
        check("mrst.imm",  rsp_imm, 32'd0);
        check("mrst.fmt",  32'(rsp_fmt), 32'd0);
        check("mrst.id",   32'(rsp_id), 32'd0);
        check("mrst.prio0", 32'(req0_ready), 32'd1);
        check("mrst.prio1", 32'(req1_ready), 32'd0);
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("post.vld", 32'(rsp_valid), 32'd1);
        check("post.id",  32'(rsp_id), 32'd0);
        check("post.imm", rsp_imm, 32'hFFFFFFFC);
        check("post.fmt", 32'(rsp_fmt), 32'd2);
        next_cycle();
        @(negedge clk);
        check("drain.vld", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_arbiter.md
IMM_ARBITER -- requirements
Module: imm_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, default 0, index of the requester holding round-robin priority after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 presents an instruction.
REQ-005 req0_inst  input  32  requester 0 instruction word.
REQ-006 req0_ready  output  1  requester 0 instruction accepted this cycle when high with req0_valid.
REQ-007 req1_valid  input  1  requester 1 presents an instruction.
REQ-008 req1_inst  input  32  requester 1 instruction word.
REQ-009 req1_ready  output  1  requester 1 instruction accepted this cycle when high with req1_valid.
REQ-010 rsp_valid  output  1  response register holds a valid result.
REQ-011 rsp_ready  input  1  consumer takes the response this cycle.
REQ-012 rsp_imm  output  32  sign-extended immediate of the granted instruction.
REQ-013 rsp_id  output  1  index of the requester that owns the response.
REQ-014 rsp_fmt  output  3  format code: 0 I, 1 JALR, 2 S, 3 U, 4 UJ, 5 SB, 6 unrecognised (I-style decode).

Function
REQ-015 The block SHALL share one combinational immediate generator between both requesters; only the granted instruction drives it.
REQ-016 Format key SHALL be {inst[6:5],inst[3:2]}: 0000 I, 1101 JALR, 0100 S, 0101/0001 U, 1111 UJ, 1100 SB, any other key fmt 6.
REQ-017 Immediates SHALL follow RV32I: I/fmt6 sign(inst[31]) and inst[30:20]; JALR as I with bit 0 forced to 0; S inst[31:25],inst[11:7]; U inst[31:12] followed by 12 zeros; UJ inst[31],inst[19:12],inst[20],inst[30:21],0; SB inst[31],inst[7],inst[30:25],inst[11:8],0.
REQ-018 States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-019 Accept condition: slot_free = EMPTY, or FULL with rsp_ready=1 (throughput 1 response/cycle).
REQ-020 When slot_free and exactly one requester is valid, that requester's ready SHALL be 1.
REQ-021 When slot_free and both are valid, only the priority holder's ready SHALL be 1.
REQ-022 When slot_free is false, req0_ready and req1_ready SHALL both be 0; ready SHALL never be asserted to a non-valid requester.
REQ-023 Priority SHALL move to the other requester after each grant and SHALL be unchanged in cycles without a grant.
REQ-024 Latency: an instruction accepted in cycle N SHALL appear on rsp_imm, rsp_fmt and rsp_id with rsp_valid=1 in cycle N+1.
REQ-025 While FULL and rsp_ready=0: rsp_imm, rsp_fmt and rsp_id SHALL hold stable.
REQ-026 State transitions:
- FULL with rsp_ready=1 and no grant -> EMPTY.
- FULL with rsp_ready=1 and a grant -> stays FULL with the new payload.
- EMPTY with a grant -> FULL.
REQ-027 Requester inputs SHALL be sampled only in the grant cycle; later changes SHALL not affect the held response.

Reset
REQ-028 In any cycle with reset=1, including mid-transaction, the block SHALL:
- go to EMPTY and discard any held response;
- drive rsp_valid=0, rsp_imm=0, rsp_fmt=0, rsp_id=0;
- set priority to PRIO_INIT.
REQ-029 req0_ready and req1_ready SHALL be 0 in any cycle with reset=1.
REQ-030 First grant is possible in the cycle after reset deasserts.

Verification
REQ-031 Single request: req0 valid with 0xFFF00093, rsp_ready=1 -> next cycle rsp_valid=1, rsp_imm=0xFFFFFFFF, fmt=0, id=0.
REQ-032 Format sweep, each decoded one cycle after its grant:
- 0x12345037 -> imm 0x12345000, fmt 3;
- 0xFE112E23 -> imm 0xFFFFFFFC, fmt 2;
- 0x0040006F -> imm 0x00000004, fmt 4.
REQ-033 Contention: both valid every cycle, PRIO_INIT=0, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id alternates one cycle later.
REQ-034 Backpressure: rsp_ready=0 for 3 cycles while FULL -> both readies 0; response stable; priority unchanged; release -> next grant issues in that same cycle.
REQ-035 Reset mid-operation: reset=1 while FULL with rsp_ready=0 -> next cycle rsp_valid=0, all outputs 0, priority=PRIO_INIT.
REQ-036 Unrecognised key: inst 0x80000013 with bit 4 cleared (0x80000003 treated as key 0000 is I), and 0x8000000B (key 0010) -> rsp_fmt=6, rsp_imm=0xFFFFF800.
